alu_dmem_unit: RTL and testbench
================================

ALU_DMEM_UNIT -- requirements
Module: alu_dmem_unit

Interface
REQ-001 SHALL have port Clock, input, 1: single system clock; all sequential logic on its rising edge.
REQ-002 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port ALUOp, input, 2: ALU operation class from the control unit.
REQ-004 SHALL have port Opcode, input, 4: instruction[15:12].
REQ-005 SHALL have port Funct, input, 2: instruction[1:0], R-format function code.
REQ-006 SHALL have port A, input, 16: ALU operand A (register rs).
REQ-007 SHALL have port B, input, 16: ALU operand B (rt or sign-extended immediate).
REQ-008 SHALL have port MemRead, input, 1: data-memory read enable.
REQ-009 SHALL have port MemWrite, input, 1: data-memory write enable.
REQ-010 SHALL have port WriteData, input, 16: store data (register rt).
REQ-011 SHALL have port ALUCtrl, output, 4: decoded control {Ainvert, Bnegate, Op[1:0]}.
REQ-012 SHALL have port Result, output, 16: ALU result; also the data-memory byte address.
REQ-013 SHALL have ports Zero, Overflow and CarryOut, each output, 1: ALU flags.
REQ-014 SHALL have port ReadData, output, 16: load data.
REQ-015 SHALL have port OvfSticky, output, 1: sticky overflow flag (see Configuration).

Function
REQ-016 ALUCtrl SHALL be decoded combinationally from ALUOp, Opcode and Funct as follows.
- ALUOp=00: 0010 (ADD, lw/sw).
- ALUOp=01: 0110 (SUB, beq).
- ALUOp=10 with Opcode=0000: Funct 00 gives AND 0000; 01 gives OR 0001; 10 gives ADD 0010; 11 gives SUB 0110.
- ALUOp=10 with Opcode=0001: Funct 00 gives SLT 0111; 01 gives NOR 1100; otherwise ADD.
- ALUOp=10 with any other Opcode: ADD.
REQ-017 For ALUOp=11, ALUCtrl SHALL be: Opcode 0100 ADD; 0101 SUB; 0110 SLT; 0111 AND; 1000 OR; any other Opcode ADD.
REQ-018 ALU operands SHALL be a = Ainvert ? ~A : A and b = Bnegate ? ~B : B; the adder SHALL compute a + b + Bnegate (16-bit, two's complement).
REQ-019 Op SHALL select the Result source: 00 gives a&b; 01 gives a|b; 10 gives the adder sum; 11 gives SLT.
REQ-020 SLT SHALL set Result = {15'b0, sum[15]^Overflow}, i.e. 1 when A < B as signed values.
REQ-021 Overflow SHALL be set when the adder inputs have equal sign bits and sum[15] differs from them; CarryOut SHALL be the adder's bit-16 carry; both SHALL be valid for every Op.
REQ-022 Zero SHALL be 1 exactly when Result == 16'h0000.
REQ-023 The whole ALU path SHALL be combinational, with zero-cycle latency.
REQ-024 Data memory SHALL be 64 words x 16 bits, byte-addressed; the word index SHALL be Result[6:1]; Result[0] and Result[15:7] SHALL be ignored, so addresses wrap modulo 128.
REQ-025 On a rising Clock edge with MemWrite=1 and Reset=0, mem[Result[6:1]] SHALL be loaded with WriteData.
REQ-026 ReadData SHALL be combinational: mem[Result[6:1]] when MemRead=1, else 16'h0000.
REQ-027 When MemRead and MemWrite are both 1, ReadData SHALL show the old word until the clock edge, and the write SHALL occur.

Reset
REQ-028 Reset=1 SHALL asynchronously clear all 64 memory words and OvfSticky to 0, and SHALL block writes while asserted.
REQ-029 Combinational outputs SHALL NOT depend on Reset, except that ReadData reflects the cleared memory.

Configuration
REQ-030 With macro ALU_STICKY_OVF_EN defined, OvfSticky SHALL be set at any rising Clock edge where Overflow=1, and SHALL hold until Reset.
REQ-031 Without ALU_STICKY_OVF_EN, OvfSticky SHALL be tied to 0 and no register SHALL be inferred for it.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- ALUOp=00, A=0x0005, B=0x0003: Result=0x0008, Zero=0, ALUCtrl=0010.
- ALUOp=01, A=B=0x1234: Result=0, Zero=1, CarryOut=1, ALUCtrl=0110.
- ALUOp=10, Opcode=0000, Funct=10, A=0x7FFF, B=0x0001: Result=0x8000, Overflow=1; OvfSticky=1 after the edge only when the macro is defined.
- ALUOp=11, Opcode=0110, A=0xFFFF, B=0x0001: Result=0x0001 (signed -1 < 1).
- MemWrite at Result=0x0010 with WriteData=0xBEEF, then MemRead at 0x0011: ReadData=0xBEEF; MemRead=0 gives ReadData=0.
- Reset pulse mid-cycle after a write: ReadData reads 0 immediately, and OvfSticky=0.

Source files
------------

// File: rtl/alu_dmem_unit.sv
// 16-bit ALU with control decode plus a 64x16 byte-addressed data memory.
// Optional sticky overflow flag is built only when ALU_STICKY_OVF_EN is defined.
module alu_dmem_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [1:0]  ALUOp,
    input  logic [3:0]  Opcode,
    input  logic [1:0]  Funct,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] WriteData,
    output logic [3:0]  ALUCtrl,
    output logic [15:0] Result,
    output logic        Zero,
    output logic        Overflow,
    output logic        CarryOut,
    output logic [15:0] ReadData,
    output logic        OvfSticky
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    always_comb begin
        ALUCtrl = CTRL_ADD;
        case (ALUOp)
            2'b00: ALUCtrl = CTRL_ADD;
            2'b01: ALUCtrl = CTRL_SUB;
            2'b10: begin
                if (Opcode == 4'b0000) begin
                    case (Funct)
                        2'b00:   ALUCtrl = CTRL_AND;
                        2'b01:   ALUCtrl = CTRL_OR;
                        2'b10:   ALUCtrl = CTRL_ADD;
                        default: ALUCtrl = CTRL_SUB;
                    endcase
                end else if (Opcode == 4'b0001) begin
                    case (Funct)
                        2'b00:   ALUCtrl = CTRL_SLT;
                        2'b01:   ALUCtrl = CTRL_NOR;
                        default: ALUCtrl = CTRL_ADD;
                    endcase
                end else begin
                    ALUCtrl = CTRL_ADD;
                end
            end
            default: begin
                case (Opcode)
                    4'b0100: ALUCtrl = CTRL_ADD;
                    4'b0101: ALUCtrl = CTRL_SUB;
                    4'b0110: ALUCtrl = CTRL_SLT;
                    4'b0111: ALUCtrl = CTRL_AND;
                    4'b1000: ALUCtrl = CTRL_OR;
                    default: ALUCtrl = CTRL_ADD;
                endcase
            end
        endcase
    end

    logic        ainvert;
    logic        bnegate;
    logic [1:0]  op;
    logic [15:0] a_op;
    logic [15:0] b_op;
    logic [16:0] sum_full;
    logic [15:0] sum;

    assign {ainvert, bnegate, op} = ALUCtrl;
    assign a_op     = ainvert ? ~A : A;
    assign b_op     = bnegate ? ~B : B;
    // Bnegate doubles as the carry-in so SUB/SLT form a + ~b + 1.
    assign sum_full = {1'b0, a_op} + {1'b0, b_op} + {16'b0, bnegate};
    assign sum      = sum_full[15:0];
    assign CarryOut = sum_full[16];
    assign Overflow = (a_op[15] == b_op[15]) && (sum[15] != a_op[15]);

    always_comb begin
        Result = sum;
        case (op)
            2'b00:   Result = a_op & b_op;
            2'b01:   Result = a_op | b_op;
            2'b10:   Result = sum;
            default: Result = {15'b0, sum[15] ^ Overflow};
        endcase
    end

    assign Zero = (Result == 16'h0000);

    logic [15:0] mem [64];
    logic [5:0]  word_idx;

    // Byte address: bit 0 and bits above 6 are ignored, so addresses wrap at 128.
    assign word_idx = Result[6:1];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 64; i++) begin
                mem[6'(i)] <= 16'h0000;
            end
        end else if (MemWrite) begin
            mem[word_idx] <= WriteData;
        end
    end

    assign ReadData = MemRead ? mem[word_idx] : 16'h0000;

`ifdef ALU_STICKY_OVF_EN
    logic ovf_sticky_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf_sticky_q <= 1'b0;
        end else if (Overflow) begin
            ovf_sticky_q <= 1'b1;
        end
    end

    assign OvfSticky = ovf_sticky_q;
`else
    assign OvfSticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dmem_unit.sv
// Bench for alu_dmem_unit: directed vector table, memory/reset sequences, and
// randomized traffic against a behavioural model of the ALU and memory.
module tb_alu_dmem_unit;

    logic        Clock;
    logic        Reset;
    logic [1:0]  ALUOp;
    logic [3:0]  Opcode;
    logic [1:0]  Funct;
    logic [15:0] A;
    logic [15:0] B;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] WriteData;
    logic [3:0]  ALUCtrl;
    logic [15:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        CarryOut;
    logic [15:0] ReadData;
    logic        OvfSticky;

    alu_dmem_unit dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ALUOp     (ALUOp),
        .Opcode    (Opcode),
        .Funct     (Funct),
        .A         (A),
        .B         (B),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .WriteData (WriteData),
        .ALUCtrl   (ALUCtrl),
        .Result    (Result),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .CarryOut  (CarryOut),
        .ReadData  (ReadData),
        .OvfSticky (OvfSticky)
    );

`ifdef ALU_STICKY_OVF_EN
    localparam logic STICKY_EXP = 1'b1;
`else
    localparam logic STICKY_EXP = 1'b0;
`endif

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [15:0] res;
        logic        z;
        logic        ovf;
        logic        cy;
    } alu_out_t;

    typedef struct packed {
        logic [1:0]  aluop;
        logic [3:0]  opcode;
        logic [1:0]  funct;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  ctrl;
        logic [15:0] res;
        logic        z;
        logic        ovf;
        logic        cy;
    } vec_t;

    // behavioural reference model
    function automatic logic [3:0] ref_ctrl(logic [1:0] aluop, logic [3:0] opc, logic [1:0] fn);
        logic [3:0] c;
        c = 4'b0010;
        if (aluop == 2'b01) c = 4'b0110;
        else if (aluop == 2'b10) begin
            if (opc == 4'd0) c = (fn == 2'd0) ? 4'b0000 : (fn == 2'd1) ? 4'b0001 :
                                 (fn == 2'd2) ? 4'b0010 : 4'b0110;
            else if (opc == 4'd1) c = (fn == 2'd0) ? 4'b0111 : (fn == 2'd1) ? 4'b1100 : 4'b0010;
        end else if (aluop == 2'b11) begin
            case (opc)
                4'd5:    c = 4'b0110;
                4'd6:    c = 4'b0111;
                4'd7:    c = 4'b0000;
                4'd8:    c = 4'b0001;
                default: c = 4'b0010;
            endcase
        end
        return c;
    endfunction

    function automatic alu_out_t ref_alu(logic [1:0] aluop, logic [3:0] opc, logic [1:0] fn,
                                         logic [15:0] av, logic [15:0] bv);
        alu_out_t    o;
        logic [15:0] ua;
        logic [15:0] ub;
        logic        cin;
        int unsigned usum;
        int          ssum;
        o.ctrl = ref_ctrl(aluop, opc, fn);
        cin    = o.ctrl[2];
        ua     = o.ctrl[3] ? ~av : av;
        ub     = cin ? ~bv : bv;
        usum   = 32'(ua) + 32'(ub) + 32'(cin);
        ssum   = int'($signed(ua)) + int'($signed(ub)) + int'(cin);
        o.cy   = (usum > 32'd65535);
        o.ovf  = (ssum > 32767) || (ssum < -32768);
        case (o.ctrl)
            4'b0000: o.res = av & bv;
            4'b0001: o.res = av | bv;
            4'b0110: o.res = av - bv;
            4'b0111: o.res = {15'b0, ($signed(av) < $signed(bv))};
            4'b1100: o.res = ~(av | bv);
            default: o.res = av + bv;
        endcase
        o.z = (o.res == 16'h0000);
        return o;
    endfunction

    logic [15:0] mem_m [64];
    logic        sticky_m;

    always @(posedge Clock or posedge Reset) begin
        alu_out_t m;
        if (Reset) begin
            for (int i = 0; i < 64; i++) mem_m[i] = 16'h0000;
            sticky_m = 1'b0;
        end else begin
            m = ref_alu(ALUOp, Opcode, Funct, A, B);
            if (MemWrite) mem_m[int'(m.res[6:1])] = WriteData;
            if (m.ovf && STICKY_EXP) sticky_m = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after a rising edge, sampled at the falling edge
    task automatic drive(input logic [1:0] aluop, input logic [3:0] opc, input logic [1:0] fn,
                         input logic [15:0] av, input logic [15:0] bv,
                         input logic mr, input logic mw, input logic [15:0] wd);
        @(posedge Clock);
        #1;
        ALUOp = aluop; Opcode = opc; Funct = fn; A = av; B = bv;
        MemRead = mr; MemWrite = mw; WriteData = wd;
        #4;
    endtask

    task automatic do_reset();
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    vec_t vecs [17];

    initial begin
        alu_out_t m;
        logic [15:0] e;

        ALUOp = 2'b00; Opcode = 4'd0; Funct = 2'd0; A = 16'd0; B = 16'd0;
        MemRead = 1'b0; MemWrite = 1'b0; WriteData = 16'd0;
        Reset = 1'b1;
        #12;
        Reset = 1'b0;

        // reset state
        check("rst_sticky", {31'b0, OvfSticky}, 32'd0);
        MemRead = 1'b1;
        #1;
        check("rst_readdata", {16'b0, ReadData}, 32'd0);
        MemRead = 1'b0;

        //          aluop  opc    fn     a         b         ctrl     res       z     ovf   cy
        vecs[0]  = {2'b00, 4'h0, 2'd0, 16'h0005, 16'h0003, 4'b0010, 16'h0008, 1'b0, 1'b0, 1'b0};
        vecs[1]  = {2'b01, 4'h0, 2'd0, 16'h1234, 16'h1234, 4'b0110, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2]  = {2'b10, 4'h0, 2'd2, 16'h7FFF, 16'h0001, 4'b0010, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = {2'b11, 4'h6, 2'd0, 16'hFFFF, 16'h0001, 4'b0111, 16'h0001, 1'b0, 1'b0, 1'b1};
        vecs[4]  = {2'b10, 4'h0, 2'd0, 16'hF0F0, 16'hFF00, 4'b0000, 16'hF000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = {2'b10, 4'h0, 2'd1, 16'hF0F0, 16'h0F00, 4'b0001, 16'hFFF0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = {2'b10, 4'h1, 2'd1, 16'h00F0, 16'h0F00, 4'b1100, 16'hF00F, 1'b0, 1'b0, 1'b1};
        vecs[7]  = {2'b10, 4'h1, 2'd0, 16'h0003, 16'h0005, 4'b0111, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = {2'b11, 4'h5, 2'd0, 16'h8000, 16'h0001, 4'b0110, 16'h7FFF, 1'b0, 1'b1, 1'b1};
        vecs[9]  = {2'b11, 4'h7, 2'd0, 16'hFFFF, 16'h0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[10] = {2'b11, 4'h8, 2'd0, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = {2'b11, 4'h4, 2'd0, 16'hFFFF, 16'h0001, 4'b0010, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[12] = {2'b11, 4'hF, 2'd3, 16'h0001, 16'h0001, 4'b0010, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[13] = {2'b10, 4'h2, 2'd3, 16'h8000, 16'h8000, 4'b0010, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[14] = {2'b10, 4'h1, 2'd3, 16'h0001, 16'h0002, 4'b0010, 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[15] = {2'b10, 4'h0, 2'd3, 16'h0003, 16'h0005, 4'b0110, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[16] = {2'b11, 4'h6, 2'd0, 16'h8000, 16'h0001, 4'b0111, 16'h0001, 1'b0, 1'b1, 1'b1};

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].aluop, vecs[i].opcode, vecs[i].funct, vecs[i].a, vecs[i].b,
                  1'b0, 1'b0, 16'h0000);
            check($sformatf("vec%0d_ctrl", i), {28'b0, ALUCtrl}, {28'b0, vecs[i].ctrl});
            check($sformatf("vec%0d_result", i), {16'b0, Result}, {16'b0, vecs[i].res});
            check($sformatf("vec%0d_zero", i), {31'b0, Zero}, {31'b0, vecs[i].z});
            check($sformatf("vec%0d_ovf", i), {31'b0, Overflow}, {31'b0, vecs[i].ovf});
            check($sformatf("vec%0d_carry", i), {31'b0, CarryOut}, {31'b0, vecs[i].cy});
        end

        // sticky overflow: clear, present an overflowing add, then watch the edge
        do_reset();
        drive(2'b10, 4'h0, 2'd2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0000);
        check("sticky_before_edge", {31'b0, OvfSticky}, 32'd0);
        @(posedge Clock);
        #1;
        check("sticky_after_edge", {31'b0, OvfSticky}, {31'b0, STICKY_EXP});
        drive(2'b00, 4'h0, 2'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0000);
        @(posedge Clock);
        #1;
        check("sticky_hold", {31'b0, OvfSticky}, {31'b0, STICKY_EXP});

        // memory: write, read back, read disabled, address wrap, read-during-write
        drive(2'b00, 4'h0, 2'd0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
        drive(2'b00, 4'h0, 2'd0, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h0000);
        check("mem_read_0011", {16'b0, ReadData}, 32'h0000BEEF);
        drive(2'b00, 4'h0, 2'd0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'h0000);
        check("mem_read_off", {16'b0, ReadData}, 32'd0);
        drive(2'b00, 4'h0, 2'd0, 16'h0090, 16'h0000, 1'b1, 1'b0, 16'h0000);
        check("mem_wrap_0090", {16'b0, ReadData}, 32'h0000BEEF);
        drive(2'b00, 4'h0, 2'd0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h1111);
        check("mem_rdw_old", {16'b0, ReadData}, 32'h0000BEEF);
        drive(2'b00, 4'h0, 2'd0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000);
        check("mem_rdw_new", {16'b0, ReadData}, 32'h00001111);

        // mid-cycle reset clears memory immediately and blocks a write held across an edge
        #1;
        Reset = 1'b1;
        #1;
        check("midrst_readdata", {16'b0, ReadData}, 32'd0);
        check("midrst_sticky", {31'b0, OvfSticky}, 32'd0);
        MemWrite = 1'b1;
        WriteData = 16'h2222;
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        MemWrite = 1'b0;
        #1;
        check("rst_blocks_write", {16'b0, ReadData}, 32'd0);

        // randomized traffic against the model, small addresses to force reuse
        for (int n = 0; n < 250; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
            m = ref_alu(ALUOp, Opcode, Funct, A, B);
            check("rnd_ctrl", {28'b0, ALUCtrl}, {28'b0, m.ctrl});
            check("rnd_result", {16'b0, Result}, {16'b0, m.res});
            check("rnd_flags", {29'b0, Zero, Overflow, CarryOut}, {29'b0, m.z, m.ovf, m.cy});
            check("rnd_sticky", {31'b0, OvfSticky}, {31'b0, sticky_m});
            exp_q.push_back(MemRead ? mem_m[int'(m.res[6:1])] : 16'h0000);
            e = exp_q.pop_front();
            check("rnd_readdata", {16'b0, ReadData}, {16'b0, e});
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
